// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: accepts PCs, runs one imem req/ack at a time and queues {pc, instr} for decode.
// Optional build macro IF_PERF_CNT_EN adds the perf_fetched / perf_stall counter outputs.
module if_fetch_unit #(
  parameter int DEPTH = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_in,
  input  logic          pc_valid,
  output logic          pc_ready,
  input  logic          flush,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic          if_valid,
  output logic [DW-1:0] if_instr,
  output logic [AW-1:0] if_pc,
  input  logic          id_ready
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_stall
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_REQ   = 2'b01;
  localparam logic [1:0] ST_DRAIN = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] fifo_pc_q    [DEPTH];
  logic [DW-1:0] fifo_instr_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          accept_s, push_s, pop_s;

  // A PC is only taken when a FIFO slot is guaranteed for its result, so an ack never meets a full FIFO.
  always_comb begin
    pc_ready = (state_q == ST_IDLE) && !flush && (count_q < CW'(DEPTH));
    accept_s = pc_valid && pc_ready;
    push_s   = (state_q == ST_REQ) && imem_ack && !flush;
    pop_s    = (count_q != {CW{1'b0}}) && id_ready;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_REQ;
          pc_d    = pc_in;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (imem_ack) begin
          state_d = ST_IDLE;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_REQ;
        end
      end
      // Request cannot be withdrawn: wait out the ack of the squashed fetch.
      ST_DRAIN: begin
        if (imem_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= {AW{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Flush beats same-cycle push and pop; push cannot coincide with flush anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]    <= {AW{1'b0}};
        fifo_instr_q[i] <= {DW{1'b0}};
      end
    end else if (flush) begin
      count_q  <= {CW{1'b0}};
      rd_ptr_q <= wr_ptr_q;
    end else begin
      if (push_s) begin
        fifo_pc_q[wr_ptr_q]    <= pc_q;
        fifo_instr_q[wr_ptr_q] <= imem_rdata;
        wr_ptr_q               <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push_s && !pop_s) begin
        count_q <= count_q + CW'(1);
      end else if (pop_s && !push_s) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign imem_req  = (state_q != ST_IDLE);
  assign imem_addr = {pc_q[AW-1:2], 2'b00};
  assign if_valid  = (count_q != {CW{1'b0}});
  assign if_pc     = fifo_pc_q[rd_ptr_q];
  assign if_instr  = fifo_instr_q[rd_ptr_q];

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  // Counters survive flush and wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      if (push_s) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (pc_valid && !pc_ready) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a randomized run against a queue-based model.
module tb_if_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset, pc_valid, flush, imem_ack, id_ready;
  logic [31:0] pc_in, imem_rdata;
  logic        pc_ready, imem_req, if_valid;
  logic [31:0] imem_addr, if_instr, if_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  always #5 clk = ~clk;

  if_fetch_unit #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready)
`ifdef IF_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] salt;
  int wcnt = 0;

  // Reference model: one outstanding fetch plus an ordered queue of results.
  bit          m_busy = 1'b0;
  bit          m_drop = 1'b0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] mq_pc[$];
  logic [31:0] mq_in[$];
  int unsigned m_fetched = 0;
  int unsigned m_stall = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ salt[31:16], ~a[31:16] ^ salt[15:0]};
  endfunction

  task automatic model_update();
    bit exp_rdy, push;
    if (reset) begin
      mq_pc.delete(); mq_in.delete();
      m_busy = 1'b0; m_drop = 1'b0; m_fetched = 0; m_stall = 0;
    end else begin
      exp_rdy = !m_busy && !flush && (mq_pc.size() < DEPTH);
      if (pc_valid && !exp_rdy) m_stall++;
      push = m_busy && imem_ack && !m_drop && !flush;
      if (flush) begin
        mq_pc.delete(); mq_in.delete();
      end else begin
        if (mq_pc.size() > 0 && id_ready) begin
          void'(mq_pc.pop_front()); void'(mq_in.pop_front());
        end
        if (push) begin
          mq_pc.push_back(m_pc); mq_in.push_back(imem_rdata); m_fetched++;
        end
      end
      if (m_busy && imem_ack) begin
        m_busy = 1'b0; m_drop = 1'b0;
      end else if (m_busy && flush) begin
        m_drop = 1'b1;
      end else if (!m_busy && pc_valid && exp_rdy) begin
        m_busy = 1'b1; m_pc = pc_in; m_drop = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    pc_valid = 1'b0; flush = 1'b0; imem_ack = 1'b0; pc_in = 32'd0; imem_rdata = 32'd0;
  endtask

  // Memory responder: ack after a random number of request cycles, data derived from the address.
  task automatic drive_mem(input int wait_max);
    if (imem_req) begin
      if (wcnt <= 0) begin
        imem_ack = 1'b1; imem_rdata = mem_word(imem_addr); wcnt = $urandom_range(wait_max, 0);
      end else begin
        imem_ack = 1'b0; wcnt--;
      end
    end else begin
      imem_ack = 1'b0; wcnt = $urandom_range(wait_max, 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; id_ready = 1'b0; set_idle();
    tick(); tick();
    reset = 1'b0; #1;
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL reset_imem_req: got %b want 0", imem_req); end
    n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
    n_checks++; if (if_instr !== 32'd0) begin n_errors++; $display("FAIL reset_if_instr: got %h want 0", if_instr); end
    n_checks++; if (if_pc !== 32'd0) begin n_errors++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
    n_checks++; if (imem_addr !== 32'd0) begin n_errors++; $display("FAIL reset_imem_addr: got %h want 0", imem_addr); end
    n_checks++; if (pc_ready !== 1'b1) begin n_errors++; $display("FAIL reset_pc_ready: got %b want 1", pc_ready); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] pcs[3];
    logic [31:0] ins[3];
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
    for (int i = 0; i < 3; i++) ins[i] = $urandom;
    set_idle(); id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_in = pcs[i]; pc_valid = 1'b1; imem_ack = 1'b0; #1;
      n_checks++; if (pc_ready !== 1'b1) begin n_errors++; $display("FAIL zw_pc_ready[%0d]: got %b want 1", i, pc_ready); end
      if (i > 0) begin
        n_checks++; if (if_valid !== 1'b1 || if_pc !== pcs[i-1] || if_instr !== ins[i-1]) begin
          n_errors++; $display("FAIL zw_out[%0d]: got v=%b pc=%h in=%h want v=1 pc=%h in=%h", i-1, if_valid, if_pc, if_instr, pcs[i-1], ins[i-1]);
        end
      end else begin
        n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL zw_empty: got %b want 0", if_valid); end
      end
      tick();
      pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = ins[i]; #1;
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== pcs[i] || pc_ready !== 1'b0) begin
        n_errors++; $display("FAIL zw_req[%0d]: got req=%b addr=%h rdy=%b want req=1 addr=%h rdy=0", i, imem_req, imem_addr, pc_ready, pcs[i]);
      end
      tick();
    end
    imem_ack = 1'b0; #1;
    n_checks++; if (if_valid !== 1'b1 || if_pc !== pcs[2] || if_instr !== ins[2]) begin
      n_errors++; $display("FAIL zw_out[2]: got v=%b pc=%h in=%h want v=1 pc=%h in=%h", if_valid, if_pc, if_instr, pcs[2], ins[2]);
    end
    tick();
    n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL zw_drained: got %b want 0", if_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] pcs[4];
    int idx = 0;
    int popidx = 0;
    reset = 1'b1; set_idle(); tick(); reset = 1'b0;
    for (int i = 0; i < 4; i++) pcs[i] = $urandom & 32'hFFFF_FFFC;
    id_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      pc_valid = (idx < 4); pc_in = pcs[(idx < 4) ? idx : 3]; drive_mem(2); #1;
      if (mq_pc.size() == DEPTH) begin
        n_checks++; if (pc_ready !== 1'b0) begin n_errors++; $display("FAIL bp_full_ready: got %b want 0", pc_ready); end
      end
      if (pc_valid && pc_ready) idx++;
      tick();
    end
    n_checks++; if (idx !== 2) begin n_errors++; $display("FAIL bp_accepted: got %0d want 2", idx); end
    n_checks++; if (if_valid !== 1'b1 || if_pc !== pcs[0] || imem_req !== 1'b0) begin
      n_errors++; $display("FAIL bp_held: got v=%b pc=%h req=%b want v=1 pc=%h req=0", if_valid, if_pc, imem_req, pcs[0]);
    end
    id_ready = 1'b1;
    for (int c = 0; c < 60 && popidx < 4; c++) begin
      pc_valid = (idx < 4); pc_in = pcs[(idx < 4) ? idx : 3]; drive_mem(2); #1;
      if (if_valid) begin
        n_checks++; if (if_pc !== pcs[popidx] || if_instr !== mem_word(pcs[popidx])) begin
          n_errors++; $display("FAIL bp_order[%0d]: got pc=%h in=%h want pc=%h in=%h", popidx, if_pc, if_instr, pcs[popidx], mem_word(pcs[popidx]));
        end
        popidx++;
      end
      if (pc_valid && pc_ready) idx++;
      tick();
    end
    n_checks++; if (popidx !== 4) begin n_errors++; $display("FAIL bp_drained: got %0d want 4", popidx); end
    set_idle(); tick();
`ifdef IF_PERF_CNT_EN
    n_checks++; if (perf_fetched !== 32'd4) begin n_errors++; $display("FAIL perf_fetched: got %0d want 4", perf_fetched); end
    n_checks++; if (perf_stall !== m_stall) begin n_errors++; $display("FAIL perf_stall: got %0d want %0d", perf_stall, m_stall); end
`endif
  endtask

  task automatic test_flush_inflight();
    set_idle(); id_ready = 1'b1;
    pc_in = 32'h40; pc_valid = 1'b1; #1;
    n_checks++; if (pc_ready !== 1'b1) begin n_errors++; $display("FAIL fl_accept: got %b want 1", pc_ready); end
    tick();
    pc_valid = 1'b0; flush = 1'b1; #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || pc_ready !== 1'b0) begin
      n_errors++; $display("FAIL fl_req: got req=%b addr=%h rdy=%b want req=1 addr=40 rdy=0", imem_req, imem_addr, pc_ready);
    end
    tick();
    flush = 1'b0; pc_in = 32'h100; pc_valid = 1'b1; #1;
    n_checks++; if (imem_req !== 1'b1 || pc_ready !== 1'b0 || if_valid !== 1'b0) begin
      n_errors++; $display("FAIL fl_drain: got req=%b rdy=%b v=%b want req=1 rdy=0 v=0", imem_req, pc_ready, if_valid);
    end
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF; #1;
    n_checks++; if (pc_ready !== 1'b0) begin n_errors++; $display("FAIL fl_ack_rdy: got %b want 0", pc_ready); end
    tick();
    imem_ack = 1'b0; #1;
    n_checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || pc_ready !== 1'b1) begin
      n_errors++; $display("FAIL fl_after: got v=%b req=%b rdy=%b want v=0 req=0 rdy=1", if_valid, imem_req, pc_ready);
    end
    tick();
    pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = mem_word(32'h100); #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin
      n_errors++; $display("FAIL fl_next_req: got req=%b addr=%h v=%b want req=1 addr=100 v=0", imem_req, imem_addr, if_valid);
    end
    tick();
    imem_ack = 1'b0; #1;
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== mem_word(32'h100)) begin
      n_errors++; $display("FAIL fl_next_out: got v=%b pc=%h in=%h want v=1 pc=100 in=%h", if_valid, if_pc, if_instr, mem_word(32'h100));
    end
    tick();
  endtask

  task automatic test_flush_ack_pop();
    logic [31:0] a, b, c;
    a = 32'h200; b = 32'h204; c = 32'h300;
    set_idle(); id_ready = 1'b0;
    pc_in = a; pc_valid = 1'b1; #1; tick();
    pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = mem_word(a); #1; tick();
    imem_ack = 1'b0; pc_in = b; pc_valid = 1'b1; #1;
    n_checks++; if (if_valid !== 1'b1 || if_pc !== a || pc_ready !== 1'b1) begin
      n_errors++; $display("FAIL fap_one: got v=%b pc=%h rdy=%b want v=1 pc=%h rdy=1", if_valid, if_pc, pc_ready, a);
    end
    tick();
    pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = mem_word(b); flush = 1'b1; id_ready = 1'b1; #1;
    tick();
    set_idle(); #1;
    n_checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || pc_ready !== 1'b1) begin
      n_errors++; $display("FAIL fap_empty: got v=%b req=%b rdy=%b want v=0 req=0 rdy=1", if_valid, imem_req, pc_ready);
    end
    pc_in = c; pc_valid = 1'b1; tick();
    pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = mem_word(c); #1; tick();
    imem_ack = 1'b0; #1;
    n_checks++; if (if_valid !== 1'b1 || if_pc !== c || if_instr !== mem_word(c)) begin
      n_errors++; $display("FAIL fap_next: got v=%b pc=%h in=%h want v=1 pc=%h in=%h", if_valid, if_pc, if_instr, c, mem_word(c));
    end
    tick();
  endtask

  task automatic test_reset_in_req();
    logic [31:0] d, e;
    d = 32'h400; e = 32'h408;
    set_idle(); id_ready = 1'b0;
    pc_in = d; pc_valid = 1'b1; #1; tick();
    pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = mem_word(d); #1; tick();
    imem_ack = 1'b0; pc_in = e; pc_valid = 1'b1; #1; tick();
    pc_valid = 1'b0; reset = 1'b1; #1;
    n_checks++; if (imem_req !== 1'b1 || if_valid !== 1'b1) begin
      n_errors++; $display("FAIL rr_pre: got req=%b v=%b want req=1 v=1", imem_req, if_valid);
    end
    tick();
    reset = 1'b0; #1;
    n_checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || pc_ready !== 1'b1) begin
      n_errors++; $display("FAIL rr_post: got req=%b v=%b rdy=%b want req=0 v=0 rdy=1", imem_req, if_valid, pc_ready);
    end
    imem_ack = 1'b1; imem_rdata = mem_word(e); tick();
    imem_ack = 1'b0; #1;
    n_checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_errors++; $display("FAIL rr_stale_ack: got v=%b req=%b want v=0 req=0", if_valid, imem_req);
    end
    tick();
  endtask

  task automatic test_random();
    bit exp_rdy;
    reset = 1'b1; set_idle(); tick(); reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      pc_valid = ($urandom_range(3, 0) != 0);
      pc_in    = $urandom;
      flush    = ($urandom_range(11, 0) == 0);
      id_ready = ($urandom_range(1, 0) == 1);
      drive_mem(3);
      if (!imem_req && $urandom_range(9, 0) == 0) begin
        imem_ack = 1'b1; imem_rdata = $urandom;
      end
      #1;
      exp_rdy = !m_busy && !flush && (mq_pc.size() < DEPTH);
      n_checks++; if (pc_ready !== exp_rdy) begin n_errors++; $display("FAIL rnd_pc_ready@%0d: got %b want %b", c, pc_ready, exp_rdy); end
      n_checks++; if (imem_req !== m_busy) begin n_errors++; $display("FAIL rnd_imem_req@%0d: got %b want %b", c, imem_req, m_busy); end
      if (m_busy) begin
        n_checks++; if (imem_addr !== {m_pc[31:2], 2'b00}) begin
          n_errors++; $display("FAIL rnd_imem_addr@%0d: got %h want %h", c, imem_addr, {m_pc[31:2], 2'b00});
        end
      end
      n_checks++; if (if_valid !== (mq_pc.size() > 0)) begin
        n_errors++; $display("FAIL rnd_if_valid@%0d: got %b want %b", c, if_valid, (mq_pc.size() > 0));
      end
      if (mq_pc.size() > 0) begin
        n_checks++; if (if_pc !== mq_pc[0] || if_instr !== mq_in[0]) begin
          n_errors++; $display("FAIL rnd_head@%0d: got pc=%h in=%h want pc=%h in=%h", c, if_pc, if_instr, mq_pc[0], mq_in[0]);
        end
      end
      tick();
    end
    set_idle(); tick();
`ifdef IF_PERF_CNT_EN
    n_checks++; if (perf_fetched !== m_fetched) begin n_errors++; $display("FAIL rnd_perf_fetched: got %0d want %0d", perf_fetched, m_fetched); end
    n_checks++; if (perf_stall !== m_stall) begin n_errors++; $display("FAIL rnd_perf_stall: got %0d want %0d", perf_stall, m_stall); end
`endif
  endtask

  initial begin
    salt = $urandom;
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_flush_inflight();
    test_flush_ack_pop();
    test_reset_in_req();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
